// File: rtl/alu_pkg.sv
// Shared ALU op-codes and execute-stage FSM state type.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_BSUB = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_ANDN = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: result plus carry, signed-overflow, zero and negative flags.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] result,
    output logic         co,
    output logic         ovf,
    output logic         z,
    output logic         n
);

    logic [W:0] wide;

    // Carry is bit W of the unsigned (W+1)-bit add/subtract; logic ops clear it.
    always_comb begin
        wide = '0;
        co   = 1'b0;
        ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                co   = wide[W];
                ovf  = (a[W-1] == b[W-1]) && (wide[W-1] != a[W-1]);
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                co   = wide[W];
                ovf  = (a[W-1] != b[W-1]) && (wide[W-1] != a[W-1]);
            end
            OP_BSUB: begin
                wide = {1'b0, b} - {1'b0, a};
                co   = wide[W];
                ovf  = (b[W-1] != a[W-1]) && (wide[W-1] != b[W-1]);
            end
            OP_XNOR: wide = {1'b0, ~(a ^ b)};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_ANDN: wide = {1'b0, a & ~b};
            default: wide = '0;
        endcase
    end

    assign result = wide[W-1:0];
    assign z      = (wide[W-1:0] == '0);
    assign n      = wide[W-1];

endmodule

// File: rtl/alu_exec_stage.sv
// Two-cycle ALU execute stage with valid/ready handshake, accumulator and sticky overflow.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_op,
    input  logic         in_use_acc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_result,
    output logic         out_co,
    output logic         out_ovf,
    output logic         out_z,
    output logic         out_n,
    output logic [W-1:0] acc,
    output logic         sticky_ovf,
    input  logic         clr_sticky
);

    state_t       state, state_nxt;
    logic [W-1:0] a_q, b_q;
    logic [2:0]   op_q;
    logic         accept;

    logic [W-1:0] alu_result;
    logic         alu_co, alu_ovf, alu_z, alu_n;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    alu #(.W(W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .co     (alu_co),
        .ovf    (alu_ovf),
        .z      (alu_z),
        .n      (alu_n)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = accept ? ST_EXEC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // acc is sampled at the accepting edge, so a DONE-exit command sees the fresh result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            out_result <= '0;
            out_co     <= 1'b0;
            out_ovf    <= 1'b0;
            out_z      <= 1'b0;
            out_n      <= 1'b0;
            acc        <= '0;
            sticky_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q  <= in_use_acc ? acc : in_a;
                b_q  <= in_b;
                op_q <= in_op;
            end
            if (state == ST_EXEC) begin
                out_result <= alu_result;
                out_co     <= alu_co;
                out_ovf    <= alu_ovf;
                out_z      <= alu_z;
                out_n      <= alu_n;
                acc        <= alu_result;
            end
            // A completing overflow wins over a same-cycle clear.
            sticky_ovf <= (sticky_ovf && !clr_sticky) || ((state == ST_EXEC) && alu_ovf);
        end
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter W, default 4, meaning operand/result width in bits.
REQ-002 SHALL have clk  input  1  single rising-edge clock.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have in_valid  input  1  upstream command valid.
REQ-005 SHALL have in_ready  output  1  stage can accept a command this cycle.
REQ-006 SHALL have in_a  input  W  operand A.
REQ-007 SHALL have in_b  input  W  operand B.
REQ-008 SHALL have in_op  input  3  ALU control code: 000 A+B, 001 A-B, 010 B-A, 011 XNOR, 100 AND, 101 OR, 110 XOR, 111 A&~B.
REQ-009 SHALL have in_use_acc  input  1  when 1, the accumulator replaces in_a as operand A.
REQ-010 SHALL have out_valid  output  1  result/flags valid.
REQ-011 SHALL have out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have out_result  output  W  registered result.
REQ-013 SHALL have out_co, out_ovf, out_z, out_n  output  1 each  registered carry, overflow, zero and negative flags.
REQ-014 SHALL have acc  output  W  accumulator, equal to the last completed result.
REQ-015 SHALL have sticky_ovf  output  1  set by any completed operation with overflow.
REQ-016 SHALL have clr_sticky  input  1  synchronous clear of sticky_ovf.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, EXEC, DONE.
REQ-018 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready); out_valid = (state==DONE).
REQ-019 SHALL accept a command on a rising edge with in_valid and in_ready both high, latching operand A (acc if in_use_acc else in_a), in_b and in_op, and moving to EXEC.
REQ-020 SHALL, in EXEC, evaluate the latched operands combinationally and on the next edge register result and flags, write acc with the result, OR the overflow flag into sticky_ovf, and move to DONE.
REQ-021 SHALL yield out_valid high on the second edge after acceptance (latency 2); back-to-back throughput is one result per 2 cycles.
REQ-022 SHALL, in DONE with out_ready high, go to EXEC if a new command is accepted on the same edge, else to IDLE.
REQ-023 SHALL hold out_result and all flags stable while out_valid is high and out_ready is low.
REQ-024 SHALL compute arithmetic modulo 2^W, with carry the (W+1)th bit of the unsigned add/subtract and overflow the signed overflow of that operation.
REQ-025 SHALL force out_co and out_ovf to 0 for logic ops (011-111); out_n = result MSB; out_z = (result == 0).
REQ-026 SHALL read acc for in_use_acc at the accepting edge, so a command accepted on DONE exit uses the result just completed.
REQ-027 SHALL give setting priority over clearing when clr_sticky coincides with an overflowing completion.
REQ-028 SHALL ignore in_valid whenever in_ready is low; input values need not be held after acceptance.

Reset
REQ-029 SHALL, while rst_n is low, force state IDLE and out_result, all flags, acc, sticky_ovf and latched operands to 0.
REQ-030 SHALL, on reset mid-operation, discard the in-flight command with out_valid dropping immediately; in_ready is 1 on the first clock edge after rst_n rises.

Structure
REQ-031 SHALL take ALU op-code constants and the FSM state type from shared package alu_pkg.
REQ-032 SHALL instantiate the existing combinational alu module as its only sub-module, with registering done in this block.

Verification (W=4)
REQ-033 SHALL cover ADD 0111+0001 -> result 1000, OVF=1, N=1, CO=0, Z=0, sticky_ovf=1, out_valid 2 cycles after acceptance.
REQ-034 SHALL cover SUB 0011-0101 -> result 1110, CO=1, OVF=0, N=1; then B-A with the same operands -> 0010, CO=0.
REQ-035 SHALL cover XNOR 0101,0101 -> 1111, CO=0, OVF=0, N=1, Z=0; AND 1010,0101 -> 0000, Z=1.
REQ-036 SHALL cover an accumulator chain: ADD 0001+0010 then back-to-back ADD with in_use_acc=1, in_b=0011 -> result 0110, acc=0110, no idle cycle between.
REQ-037 SHALL cover backpressure: out_ready low for 5 cycles -> out_valid and outputs stable, in_ready low; out_ready high -> released next edge.
REQ-038 SHALL cover rst_n asserted in EXEC -> out_valid=0, acc=0, sticky_ovf=0 immediately; clr_sticky together with an overflowing completion -> sticky_ovf=1.
